// File: rtl/alu_issue_stage_if.sv
// Bundle for the ALU issue stage: the decoded instruction from ID, the
// forwarding sources from EX and WB, and the registered op toward the ALU.
//   slave  : the issue stage (consumes in_*/ex_*/wb_*/flush/out_ready,
//            drives in_ready and out_*)
//   master : the environment around it (upstream, bypass network, ALU)
interface alu_issue_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) ();
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_is_rtype;
    logic [2:0]        in_funct3;
    logic              in_funct7_5;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   in_rs1_data;
    logic [XLEN-1:0]   in_rs2_data;
    logic [XLEN-1:0]   in_imm;
    logic              ex_fwd_valid;
    logic              ex_fwd_is_load;
    logic [REG_AW-1:0] ex_fwd_rd;
    logic [XLEN-1:0]   ex_fwd_data;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_opcode;
    logic [XLEN-1:0]   out_operand_a;
    logic [XLEN-1:0]   out_operand_b;
    logic [REG_AW-1:0] out_rd;
    logic              out_illegal;

    modport slave (
        input  flush, in_valid, in_is_rtype, in_funct3, in_funct7_5,
               in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
               ex_fwd_valid, ex_fwd_is_load, ex_fwd_rd, ex_fwd_data,
               wb_valid, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_operand_a,
               out_operand_b, out_rd, out_illegal
    );

    modport master (
        output flush, in_valid, in_is_rtype, in_funct3, in_funct7_5,
               in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
               ex_fwd_valid, ex_fwd_is_load, ex_fwd_rd, ex_fwd_data,
               wb_valid, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_operand_a,
               out_operand_b, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the ALU.
// Decodes RV32I funct3/funct7 into a 4-bit ALU opcode, picks operand B
// (rs2 or immediate), forwards from EX/WB, stalls on load-use, and
// registers the op behind a valid/ready handshake.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_issue_stage_if.slave (instruction in, bypass, op out)
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_stage_if.slave     bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_ILL = 4'b1111;

    logic              valid_q,   valid_d;
    logic [3:0]        opcode_q,  opcode_d;
    logic [XLEN-1:0]   op_a_q,    op_a_d;
    logic [XLEN-1:0]   op_b_q,    op_b_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        dec_opcode;
    logic              dec_illegal;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;
    logic              hazard;
    logic              in_ready;
    logic              accept;

    // Unsupported encodings (SRA/SRAI, SLTU, SLL with bit30 set) still flow
    // as valid ops tagged with the illegal opcode; the ALU returns 0 for them.
    always_comb begin
        dec_opcode = OP_ILL;
        case (bus.in_funct3)
            3'b000: dec_opcode = (bus.in_is_rtype && bus.in_funct7_5) ? OP_SUB : OP_ADD;
            3'b111: dec_opcode = OP_AND;
            3'b110: dec_opcode = OP_OR;
            3'b100: dec_opcode = OP_XOR;
            3'b001: dec_opcode = bus.in_funct7_5 ? OP_ILL : OP_SLL;
            3'b101: dec_opcode = bus.in_funct7_5 ? OP_ILL : OP_SRL;
            3'b010: dec_opcode = OP_SLT;
            default: dec_opcode = OP_ILL;
        endcase
        dec_illegal = (dec_opcode == OP_ILL);
    end

    // x0 always reads zero, even if a bypass source claims to write it.
    // A load in EX is never a forwarding source; that case is a stall.
    function automatic logic [XLEN-1:0] forward(input logic [REG_AW-1:0] rs,
                                                input logic [XLEN-1:0]   rf);
        logic [XLEN-1:0] val;
        val = rf;
        if (FWD_EN) begin
            if (rs == '0)
                val = '0;
            else if (bus.ex_fwd_valid && !bus.ex_fwd_is_load && (bus.ex_fwd_rd == rs))
                val = bus.ex_fwd_data;
            else if (bus.wb_valid && (bus.wb_rd == rs))
                val = bus.wb_data;
        end
        return val;
    endfunction

    always_comb begin
        fwd_rs1 = forward(bus.in_rs1, bus.in_rs1_data);
        fwd_rs2 = forward(bus.in_rs2, bus.in_rs2_data);
    end

    // rs2 only matters for R-type; for OP-IMM those bits are immediate.
    always_comb begin
        hazard = FWD_EN && bus.in_valid && bus.ex_fwd_valid && bus.ex_fwd_is_load &&
                 (bus.ex_fwd_rd != '0) &&
                 ((bus.ex_fwd_rd == bus.in_rs1) ||
                  (bus.in_is_rtype && (bus.ex_fwd_rd == bus.in_rs2)));
    end

    // Combinational on in_*; upstream must not derive in_valid from in_ready.
    assign in_ready = rst_n && !bus.flush && !hazard && (!valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        if (bus.flush) begin
            // Data registers keep their contents; only the valid is killed.
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            opcode_d  = dec_opcode;
            op_a_d    = fwd_rs1;
            op_b_d    = bus.in_is_rtype ? fwd_rs2 : bus.in_imm;
            rd_d      = bus.in_rd;
            illegal_d = dec_illegal;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            opcode_q  <= 4'b0000;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.out_opcode    = opcode_q;
    assign bus.out_operand_a = op_a_q;
    assign bus.out_operand_b = op_b_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_illegal   = illegal_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline stage directly upstream of the ALU. Decodes RV32I funct3/funct7 fields into the ALU's 4-bit opcode and selects operand B (rs2 or immediate). Resolves operand hazards by forwarding from EX and WB, and stalls on load-use. Registers opcode and operands under a valid/ready handshake, so the ALU sees stable inputs for a full cycle.

Parameters:
XLEN, 32, operand/result width.
REG_AW, 5, register index width.
FWD_EN, 1, 1 = forwarding and load-use stall enabled; 0 = raw register-file data, no stall.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  kill the in-flight op and the incoming op.
in_valid  in  1  decoded instruction present.
in_ready  out  1  stage accepts this cycle.
in_is_rtype  in  1  1 = OP (B from rs2); 0 = OP-IMM (B from in_imm).
in_funct3  in  3  instruction funct3.
in_funct7_5  in  1  instruction bit 30.
in_rs1, in_rs2, in_rd  in  REG_AW  register indices.
in_rs1_data, in_rs2_data, in_imm  in  XLEN  register-file reads and sign-extended immediate.
ex_fwd_valid  in  1  EX stage holds a register-writing op.
ex_fwd_is_load  in  1  that op is a load; its data is not yet available.
ex_fwd_rd  in  REG_AW  EX destination.
ex_fwd_data  in  XLEN  EX result.
wb_valid  in  1  WB writing the register file this cycle.
wb_rd  in  REG_AW  WB destination.
wb_data  in  XLEN  WB data.
out_valid  out  1  registered op valid to ALU.
out_ready  in  1  downstream accepts.
out_opcode  out  4  ALU opcode.
out_operand_a, out_operand_b  out  XLEN  ALU operands.
out_rd  out  REG_AW  destination passed along.
out_illegal  out  1  unsupported encoding.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_opcode=4'b0000, operands=0, out_rd=0, out_illegal=0. in_ready is low while rst_n is low.
- Decode (combinational on inputs):
  - funct3 000 → 0000 ADD, or 0001 SUB when in_is_rtype & funct7_5.
  - 111 → 0010 AND; 110 → 0011 OR; 100 → 0100 XOR; 001 → 0101 SLL.
  - 101 → 0110 SRL if funct7_5=0; else illegal (SRA/SRAI).
  - 010 → 0111 SLT.
  - 011 (SLTU) → illegal.
  - 001 with funct7_5=1 → illegal.
  - Illegal: opcode 4'b1111, out_illegal=1. The op still flows as valid, so the ALU returns 0.
- Forwarding, per source rs in {rs1, rs2} (FWD_EN=1):
  - rs==0 → value 0, regardless of any source.
  - Else if ex_fwd_valid & !ex_fwd_is_load & ex_fwd_rd==rs → ex_fwd_data.
  - Else if wb_valid & wb_rd==rs → wb_data.
  - Else register-file data. EX has priority over WB.
- Operand select: A = forwarded rs1. B = forwarded rs2 if in_is_rtype, else in_imm.
- Load-use hazard: hazard = FWD_EN & in_valid & ex_fwd_valid & ex_fwd_is_load & ex_fwd_rd!=0 & (ex_fwd_rd==in_rs1 | (in_is_rtype & ex_fwd_rd==in_rs2)).
- in_ready = rst_n & !flush & !hazard & (!out_valid | out_ready). This is combinational and depends on in_*; upstream must not make in_valid depend on in_ready.
- Transfer: when in_valid & in_ready, all out_* are loaded at the next edge with out_valid=1. Latency is 1 cycle.
- Hold: if out_valid & !out_ready, all out_* stay bit-stable.
- Drain: if out_ready & !(in_valid & in_ready), out_valid goes to 0 next edge. Data registers may hold stale values.
- Back-to-back: with out_ready held at 1, one op per cycle, no bubble.
- Flush: has priority over everything. Next edge sets out_valid=0, and the op presented that cycle is dropped. Data registers are unchanged.
- Reset mid-operation: output state is lost immediately; no op is replayed.

Test Plan:
- ADD forward from EX: in_rs1=5, rf=0x10, ex_fwd(rd=5, data=0x100), rs2=6 rf=0x20, R-type, funct3=000 → next cycle out_opcode=0000, A=0x100, B=0x20, out_valid=1.
- Priority and x0: EX and WB both target rd=3 (EX 0xAAAA, WB 0x5555) → A=0xAAAA. With rs1=0 and wb_rd=0, wb_data=0xFFFF → A=0.
- Load-use stall: ex_fwd_is_load=1, ex_fwd_rd=7, in_rs1=7 → in_ready=0, out_valid drops. Next cycle EX clears and WB provides 0x77 → accepted, A=0x77.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 and new in_valid → outputs stable, in_ready=0. Release → pending op transfers, no duplicate, no loss.
- Decode sweep: all funct3 × funct7_5 × rtype combinations → SUB only for R-type funct7_5. SRA and SLTU give opcode 1111 and out_illegal=1. ADDI with imm=0xFFFFFFFF gives B=0xFFFFFFFF.
- Flush and async reset: flush with out_valid=1 and in_valid=1 → out_valid=0 next edge, input dropped. rst_n low mid-stream → out_valid=0 immediately, without a clock.
